// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter with a four-state memory-ready handshake FSM.
// Optional grant watchdog is compiled in when BUS_ARBITER_TIMEOUT_EN is defined.
module bus_arbiter #(
  parameter int NUM_MASTERS    = 4,
  parameter int TIMEOUT_CYCLES = 64,
  localparam int ID_W          = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_MASTERS-1:0] Bus_RQ,
  input  logic                   Bus_Mem_Ready,
  output logic [NUM_MASTERS-1:0] Bus_GRANT,
  output logic                   Grant_Valid,
  output logic [ID_W-1:0]        Grant_Id,
  output logic                   Timeout_Err
);

  typedef enum logic [1:0] {
    ARB_IDLE          = 2'd0,
    ARB_WAIT_MEM_HIGH = 2'd1,
    ARB_WAIT_RQ_LOW   = 2'd2,
    ARB_WAIT_MEM_LOW  = 2'd3
  } state_t;

  state_t                 state, state_nxt;
  logic [ID_W-1:0]        last_granted, last_nxt, id_nxt, sel, idx;
  logic [NUM_MASTERS-1:0] grant_nxt;
  logic                   found, rq_granted, tmo_fire, tmo_nxt;

  // Grant_Id always names the master currently (or most recently) granted.
  assign rq_granted = Bus_RQ[Grant_Id];

  always_comb begin
    found = 1'b0;
    sel   = last_granted;
    idx   = last_granted;
    for (int i = 1; i <= NUM_MASTERS; i++) begin
      idx = ID_W'((int'(last_granted) + i) % NUM_MASTERS);
      if (!found && Bus_RQ[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
  end

`ifdef BUS_ARBITER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wd_cnt;

  // Counts edges spent waiting for ready; cleared whenever the FSM leaves that wait.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wd_cnt <= '0;
    end else if (state == ARB_WAIT_MEM_HIGH && state_nxt == ARB_WAIT_MEM_HIGH) begin
      wd_cnt <= wd_cnt + 1'b1;
    end else begin
      wd_cnt <= '0;
    end
  end

  assign tmo_fire = (state == ARB_WAIT_MEM_HIGH) && !Bus_Mem_Ready && rq_granted &&
                    (wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign tmo_fire = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= ARB_IDLE;
      Bus_GRANT    <= '0;
      Grant_Valid  <= 1'b0;
      Grant_Id     <= '0;
      Timeout_Err  <= 1'b0;
      last_granted <= ID_W'(NUM_MASTERS - 1);
    end else begin
      state        <= state_nxt;
      Bus_GRANT    <= grant_nxt;
      Grant_Valid  <= |grant_nxt;
      Grant_Id     <= id_nxt;
      Timeout_Err  <= tmo_nxt;
      last_granted <= last_nxt;
    end
  end

  // Ready beats an abort or a watchdog expiry on the same edge.
  always_comb begin
    state_nxt = state;
    case (state)
      ARB_IDLE:
        if (found && !Bus_Mem_Ready) state_nxt = ARB_WAIT_MEM_HIGH;
      ARB_WAIT_MEM_HIGH:
        if (Bus_Mem_Ready)                 state_nxt = ARB_WAIT_RQ_LOW;
        else if (!rq_granted || tmo_fire)  state_nxt = ARB_WAIT_MEM_LOW;
      ARB_WAIT_RQ_LOW:
        if (!rq_granted) state_nxt = ARB_WAIT_MEM_LOW;
      ARB_WAIT_MEM_LOW:
        if (!Bus_Mem_Ready) state_nxt = ARB_IDLE;
      default:
        state_nxt = ARB_IDLE;
    endcase
  end

  always_comb begin
    grant_nxt = Bus_GRANT;
    id_nxt    = Grant_Id;
    last_nxt  = last_granted;
    tmo_nxt   = tmo_fire;
    case (state)
      ARB_IDLE: begin
        grant_nxt = '0;
        if (state_nxt == ARB_WAIT_MEM_HIGH) begin
          grant_nxt[sel] = 1'b1;
          id_nxt         = sel;
          last_nxt       = sel;
        end
      end
      ARB_WAIT_MEM_HIGH, ARB_WAIT_RQ_LOW:
        if (state_nxt == ARB_WAIT_MEM_LOW) grant_nxt = '0;
      default:
        grant_nxt = '0;
    endcase
  end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter NUM_MASTERS, default 4, SHALL set the number of requesting arbitration submodules (2..8).
REQ-002 Parameter TIMEOUT_CYCLES, default 64, SHALL set the grant watchdog limit in clk cycles (used only under REQ-028).
REQ-003 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 reset  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 Bus_RQ  input  NUM_MASTERS  SHALL carry the per-master bus request; bit i comes from master i's D_Bus_RQ or I_Bus_RQ.
REQ-006 Bus_Mem_Ready  input  1  SHALL be the shared bus memory-ready strobe.
REQ-007 Bus_GRANT  output  NUM_MASTERS  SHALL be the one-hot-or-zero per-master grant.
REQ-008 Grant_Valid  output  1  SHALL be the OR of Bus_GRANT.
REQ-009 Grant_Id  output  clog2(NUM_MASTERS)  SHALL be the index of the granted master; holds the last value when Grant_Valid=0.
REQ-010 Timeout_Err  output  1  SHALL be the one-cycle watchdog-expiry pulse.

Function
REQ-011 All outputs SHALL be registered; at most one Bus_GRANT bit SHALL be high in any cycle.
REQ-012 FSM states SHALL be ARB_IDLE, ARB_WAIT_MEM_HIGH, ARB_WAIT_RQ_LOW and ARB_WAIT_MEM_LOW.
REQ-013 ARB_IDLE: if any Bus_RQ bit=1 and Bus_Mem_Ready=0 at edge k, the selected bit SHALL be granted after edge k and the FSM SHALL go to ARB_WAIT_MEM_HIGH (1-cycle request-to-grant latency).
REQ-014 ARB_IDLE with Bus_Mem_Ready=1 (stale ready): no grant SHALL be issued; the FSM SHALL stay in ARB_IDLE.
REQ-015 Selection SHALL be round-robin: the search starts at index (last_granted+1) mod NUM_MASTERS, and the first set Bus_RQ bit found wins.
REQ-016 ARB_WAIT_MEM_HIGH: on Bus_Mem_Ready=1, the FSM SHALL go to ARB_WAIT_RQ_LOW with the grant held.
REQ-017 ARB_WAIT_MEM_HIGH: if the granted RQ drops while Bus_Mem_Ready=0 (abort), the grant SHALL drop next edge and the FSM SHALL go to ARB_WAIT_MEM_LOW.
REQ-018 ARB_WAIT_RQ_LOW: on granted RQ=0, the grant SHALL drop next edge and the FSM SHALL go to ARB_WAIT_MEM_LOW.
REQ-019 ARB_WAIT_MEM_LOW: on Bus_Mem_Ready=0, the FSM SHALL go to ARB_IDLE; the earliest new grant SHALL follow one edge later.
REQ-020 last_granted SHALL update only when a grant is issued.
REQ-021 Requests from non-granted masters SHALL be ignored until ARB_IDLE; no pre-emption.
REQ-022 If the granted RQ and Bus_Mem_Ready change on the same edge in ARB_WAIT_MEM_HIGH, Ready SHALL take priority (-> ARB_WAIT_RQ_LOW).
REQ-023 Illegal state encodings SHALL recover to ARB_IDLE with all grants low.

Reset
REQ-024 reset=0 SHALL immediately force: state ARB_IDLE, Bus_GRANT=0, Grant_Valid=0, Grant_Id=0, Timeout_Err=0, watchdog=0.
REQ-025 After reset, last_granted SHALL be NUM_MASTERS-1 so that master 0 has first priority.
REQ-026 Assertion of reset mid-grant SHALL drop the grant asynchronously; no memory-side handshake completion is required.
REQ-027 Deassertion SHALL take effect at the first rising clk edge at which reset=1.

Configuration
REQ-028 With BUS_ARBITER_TIMEOUT_EN defined, a counter SHALL run in ARB_WAIT_MEM_HIGH; on reaching TIMEOUT_CYCLES without Bus_Mem_Ready=1, the grant SHALL drop, Timeout_Err SHALL pulse for 1 cycle, and the FSM SHALL go to ARB_WAIT_MEM_LOW.
REQ-029 Without BUS_ARBITER_TIMEOUT_EN, no counter SHALL exist, Timeout_Err SHALL be tied 0, and ARB_WAIT_MEM_HIGH SHALL wait indefinitely.

Verification
REQ-030 Reset release, Bus_RQ=4'b0010, Ready=0 -> Bus_GRANT=4'b0010 and Grant_Id=1 one edge later; Ready 1 -> RQ 0 -> Ready 0 -> grant low, FSM back to ARB_IDLE.
REQ-031 Bus_RQ=4'b1111 held through 4 full transactions -> grant order 0,1,2,3, then 0 again.
REQ-032 Ready=1 while in ARB_IDLE with Bus_RQ=4'b0001 -> no grant until Ready=0, then grant 4'b0001 one edge later.
REQ-033 Granted master 2 drops RQ before Ready -> grant low next edge; wait Ready low; next request by master 3 granted.
REQ-034 Macro defined, TIMEOUT_CYCLES=8, Ready never rises -> grant drops and Timeout_Err=1 for one cycle 8 cycles after grant; macro undefined -> grant held for 100+ cycles and Timeout_Err=0.
REQ-035 reset=0 asserted mid-transaction while Bus_GRANT=4'b0100 -> Bus_GRANT=0 without a clock edge; after release, Bus_RQ=4'b0100 -> master 2 granted via master-0-first priority.
